// File: rtl/fact_pkg.sv
// Shared constants for the factorial accelerator: register offsets, FSM state encoding and size defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fact_pkg;

  localparam int WIDTH_DEF = 32;  // data bus / result width
  localparam int NW_DEF    = 4;   // operand n width
  localparam int N_MAX_DEF = 12;  // 12! is the largest factorial that fits in 32 bits

  // Word offsets within the peripheral window (bus address bits [3:2])
  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one WIDTH x NW multiply per cycle, sticky done/err, held result.
// Latency: done rises max(n,1) edges after the start edge; out-of-range n flags err on the start edge.
// Backpressure: start is ignored while busy; no stall inputs.
//
// Ports:
//   clk, rst      : clock, async active-high reset
//   start         : one-cycle request to begin (honoured only in IDLE)
//   n_in          : operand captured on an accepted start
//   busy          : high while a computation is in flight
//   done, err     : sticky status, cleared by the next accepted start
//   result        : last factorial (0 after an error start)
module fact_core
  import fact_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NW    = NW_DEF,
  parameter int N_MAX = N_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    n_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam logic [NW-1:0] N_LIMIT = NW'(N_MAX);
  localparam logic [NW-1:0] ONE_N   = NW'(1);

  state_e           state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    result_d  = result_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (n_in > N_LIMIT) begin
            // Overflowing operand: report immediately without entering BUSY
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            cnt_d     = n_in;
            product_d = WIDTH'(1);
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q > ONE_N) begin
          // Only the low WIDTH bits are kept; n <= N_MAX guarantees no loss
          product_d = product_q * WIDTH'(cnt_q);
          cnt_d     = cnt_q - ONE_N;
        end else begin
          // cnt of 0 or 1 terminates, which also gives 0! = 1
          result_d = product_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: N/GO/STATUS/RESULT registers around fact_core.
// Latency: register writes take effect on the we edge; reads are combinational from a.
// Backpressure: none on the bus; GO while busy is dropped, software polls STATUS.
//
// Ports:
//   clk, rst : clock, async active-high reset
//   we       : write strobe already decoded for this window
//   a        : word offset (0=N, 1=GO, 2=STATUS, 3=RESULT)
//   wd       : write data
//   rd       : read data for offset a
//   done     : sticky completion flag (LED / interrupt)
module fact_accel
  import fact_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NW    = NW_DEF,
  parameter int N_MAX = N_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       a,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             done
);

  logic [NW-1:0]    n_q, n_d;
  logic             start;
  logic             busy;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             unused_wd;

  // Only the operand bits of wd are stored; upper bits are discarded
  assign unused_wd = ^wd[WIDTH-1:NW];

  always_comb begin
    n_d = n_q;
    if (we && (a == ADDR_N)) begin
      n_d = wd[NW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= '0;
    end else begin
      n_q <= n_d;
    end
  end

  assign start = we && (a == ADDR_GO) && wd[0];

  fact_core #(
    .WIDTH (WIDTH),
    .NW    (NW),
    .N_MAX (N_MAX)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n_in   (n_q),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  always_comb begin
    rd = '0;
    case (a)
      ADDR_N:      rd = WIDTH'(n_q);
      ADDR_GO:     rd = WIDTH'(busy);
      ADDR_STATUS: rd = WIDTH'({err, done});
      ADDR_RESULT: rd = result;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed boundary cases plus random operands against a factorial model.
// Latency: checks done arrives max(n,1) edges after the GO edge.
// Backpressure: checks GO/N writes during BUSY do not disturb the running job.
module tb_fact_accel;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        done;

  int checks;
  int errors;

  fact_accel dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: n! truncated to 32 bits, computed directly from the definition
  function automatic logic [31:0] fact_ref(input int n);
    longint p;
    p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  function automatic int lat_ref(input int n);
    return (n < 2) ? 1 : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] addr, output logic [31:0] v);
    a = addr;
    #1;
    v = rd;
  endtask

  // Start a job with n and check busy flag, latency, result and status
  task automatic run_n(input int n, input string tag);
    logic [31:0] v;
    int lat;
    bus_write(2'd0, 32'(n));
    bus_write(2'd1, 32'd1);
    if (n > 12) begin
      rd_reg(2'd2, v); chk({tag, "_err_status"}, v, 32'h3);
      rd_reg(2'd3, v); chk({tag, "_err_result"}, v, 32'h0);
      rd_reg(2'd1, v); chk({tag, "_err_go"}, v, 32'h0);
    end else begin
      rd_reg(2'd1, v); chk({tag, "_busy"}, v, 32'h1);
      lat = 0;
      while (!done && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(lat_ref(n)));
      rd_reg(2'd3, v); chk({tag, "_result"}, v, fact_ref(n));
      rd_reg(2'd2, v); chk({tag, "_status"}, v, 32'h1);
      rd_reg(2'd1, v); chk({tag, "_idle"}, v, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] v;
    int lat;
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    we  = 1'b0;
    a   = 2'd0;
    wd  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      chk($sformatf("rst_reg%0d", i), v, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Decoder gating: no we means no write
    @(negedge clk);
    a  = 2'd0;
    wd = 32'd9;
    @(posedge clk);
    #1;
    rd_reg(2'd0, v); chk("gate_no_we", v, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFF7);
    rd_reg(2'd0, v); chk("n_trunc", v, 32'h7);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd_reg(2'd2, v); chk("ro_status", v, 32'h0);
    rd_reg(2'd3, v); chk("ro_result", v, 32'h0);
    rd_reg(2'd0, v); chk("ro_n_kept", v, 32'h7);

    // GO with wd[0]=0 does nothing
    bus_write(2'd1, 32'hFFFF_FFFE);
    rd_reg(2'd1, v); chk("go_bit0_clear", v, 32'h0);

    // Directed cases including boundaries and error
    run_n(5, "n5");
    run_n(0, "n0");
    run_n(1, "n1");
    run_n(12, "n12");
    rd_reg(2'd3, v); chk("n12_const", v, 32'h1C8C_FC00);
    run_n(13, "n13");
    run_n(3, "n3_after_err");

    // GO and N writes while busy are ignored by the running job
    bus_write(2'd0, 32'd6);
    bus_write(2'd1, 32'd1);
    lat = 0;
    @(posedge clk); #1; lat++;
    bus_write(2'd0, 32'd2); lat++;
    bus_write(2'd1, 32'd1); lat++;
    rd_reg(2'd0, v); chk("intf_n_updated", v, 32'h2);
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("intf_latency", 32'(lat), 32'd6);
    rd_reg(2'd3, v); chk("intf_result", v, 32'd720);
    bus_write(2'd1, 32'd1);
    while (!done && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd_reg(2'd3, v); chk("intf_next_result", v, 32'd2);

    // Random operands, including out-of-range ones
    for (int k = 0; k < 12; k++) begin
      n = int'($urandom_range(0, 15));
      run_n(n, $sformatf("rnd%0d_n%0d", k, n));
    end

    // Asynchronous reset in the middle of a computation
    run_n(7, "pre_rst");
    bus_write(2'd0, 32'd10);
    bus_write(2'd1, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_done", 32'(done), 32'h0);
    rd_reg(2'd2, v); chk("mid_rst_status", v, 32'h0);
    rd_reg(2'd3, v); chk("mid_rst_result", v, 32'h0);
    rd_reg(2'd1, v); chk("mid_rst_go", v, 32'h0);
    rd_reg(2'd0, v); chk("mid_rst_n", v, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_n(4, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
Memory-mapped iterative factorial accelerator on the data bus, mapped in the 0x0000_080x window. It consumes the peripheral write-enable the system address decoder produces for that window. Its read data feeds the processor read-back mux input selected when rdsel = 2. Software writes n, writes go, polls status, then reads the 32-bit result.

Parameters:
WIDTH, 32, data bus and result width
NW, 4, width of operand n
N_MAX, 12, largest n whose factorial fits in WIDTH bits; larger n flags error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
we  input  1  write strobe for this peripheral window (decoder output)
a  input  2  word offset within window, bus address bits [3:2]
wd  input  WIDTH  write data
rd  output  WIDTH  read data, combinational from a
done  output  1  status done bit, also usable as LED/interrupt

Behaviour:
- Register map by a: 0 = N (rw, wd[3:0]); 1 = GO (write wd[0]=1 starts; read {31'b0, busy}); 2 = STATUS (ro, {30'b0, err, done}); 3 = RESULT (ro).
- Writes to STATUS/RESULT are ignored. Writes occur only on a clk edge with we=1.
- Reset (async, immediate): n=0, state=IDLE, busy=0, done=0, err=0, result=0, product=0, cnt=0. rd follows a with these values.
- FSM states: IDLE, BUSY.
- IDLE, write GO with wd[0]=1 at edge E0:
  - Clears done and err.
  - If n > N_MAX: err<=1, done<=1, result<=0, stay IDLE.
  - Otherwise: cnt<=n, product<=1, state<=BUSY.
- IDLE, write GO with wd[0]=0: no effect.
- BUSY at each edge:
  - If cnt > 1: product<=product*cnt (low WIDTH bits), cnt<=cnt-1.
  - Else: result<=product, done<=1, state<=IDLE.
- Latency: done rises at edge E0+max(n,1). Examples: n=0 or 1 -> E0+1, result 1; n=5 -> E0+5, result 120; n=12 -> E0+12, result 479001600.
- Write GO while BUSY: ignored; the computation continues undisturbed.
- Write N while BUSY: N updates, but the in-flight computation uses the captured cnt. The new value applies to the next GO.
- done/err are sticky until the next accepted GO or reset. result holds until the next successful completion or an error GO.
- rd is purely combinational from a and the registers; no read side effects.
- Reset asserted mid-BUSY: returns to IDLE immediately with all registers at reset values.
- The multiplier is one combinational WIDTH x NW product per cycle; there is no multi-cycle multiply.

Decomposition:
- Shared package/header fact_pkg:
  - offset constants ADDR_N=0, ADDR_GO=1, ADDR_STATUS=2, ADDR_RESULT=3
  - state encoding IDLE=0, BUSY=1
  - N_MAX default
- One sub-module, fact_core: FSM, cnt, product, result, done, err. Interface: clk, rst, start, n_in, busy, done, err, result.
- fact_accel holds the N register, write-strobe qualification (we & a==offset) and the read mux.

Test Plan:
- Reset: assert rst mid-test asynchronously -> within the same cycle done=0, STATUS reads 0, RESULT reads 0, GO reads 0.
- n=5: write N=5, write GO=1 -> GO reads 1 for 5 cycles; done=1 exactly 5 edges after the GO edge; RESULT=120; STATUS=0x1.
- Boundaries: n=0 and n=1 -> done after 1 edge, RESULT=1. n=12 -> done after 12 edges, RESULT=0x1C8CFC00.
- Error: write N=13, GO=1 -> next edge STATUS=0x3, RESULT=0, GO reads 0. Then N=3, GO -> STATUS=0x1, RESULT=6.
- Interference: start n=6; at the 2nd BUSY cycle write N=2 and GO=1 -> ignored; RESULT=720 at E0+6. A following GO yields 2.
- Decoder gating: we=0 with a=0, wd=9 -> N unchanged. Write wd=0xFFFF_FFF7 to N -> N reads 7. Write to offsets 2/3 -> no change.
